// File: rtl/sys_ctrl_regs.sv
// sys_ctrl_regs: system-control register block on the SMI/IOC register bus.
//   Registers: version/ID constants, sticky maskable errors with IRQ,
//   saturating error-event counter, debug modes, scratch, soft-reset pulse.
// Latency: reads land on o_data_out at the edge that samples the fetch.
//   Writes take effect at the edge that samples the load. o_irq lags
//   sticky & mask by one clock.
// Backpressure: none. One access per clock is allowed, and back-to-back
//   strobes are legal.
// Ports:
//   i_sys_clk, i_rst       clock and asynchronous active-high reset
//   i_cs                   module select
//   i_ioc                  register address
//   i_fetch_cmd            one-clock read strobe
//   i_load_cmd             one-clock write strobe
//   i_data_in, o_data_out  write data and registered read data
//   i_error_list           synchronous error flags; captured into sticky
//   o_debug_modes          debug control bits
//   o_error_any            OR of the sticky error register
//   o_irq                  registered OR of sticky & mask
//   o_soft_rst             timed soft-reset pulse
module sys_ctrl_regs #(
  parameter int unsigned ERR_WIDTH      = 8,
  parameter int unsigned DEBUG_BITS     = 3,
  parameter int unsigned RST_PULSE_LEN  = 16,
  parameter logic [7:0]  MODULE_VERSION = 8'h02,
  parameter logic [7:0]  SYSTEM_VERSION = 8'h01,
  parameter logic [7:0]  MANU_ID        = 8'h01
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst,
  input  logic [4:0]            i_ioc,
  input  logic [7:0]            i_data_in,
  output logic [7:0]            o_data_out,
  input  logic                  i_cs,
  input  logic                  i_fetch_cmd,
  input  logic                  i_load_cmd,
  input  logic [ERR_WIDTH-1:0]  i_error_list,
  output logic [DEBUG_BITS-1:0] o_debug_modes,
  output logic                  o_error_any,
  output logic                  o_irq,
  output logic                  o_soft_rst
);

  localparam logic [4:0] A_MOD_VER = 5'h00;
  localparam logic [4:0] A_SYS_VER = 5'h01;
  localparam logic [4:0] A_MANU    = 5'h02;
  localparam logic [4:0] A_ERR_LO  = 5'h03;
  localparam logic [4:0] A_ERR_HI  = 5'h04;
  localparam logic [4:0] A_DEBUG   = 5'h05;
  localparam logic [4:0] A_SCRATCH = 5'h06;
  localparam logic [4:0] A_SRST    = 5'h07;
  localparam logic [4:0] A_MASK_LO = 5'h08;
  localparam logic [4:0] A_MASK_HI = 5'h09;
  localparam logic [4:0] A_EVCNT   = 5'h0A;

  localparam logic [7:0] SRST_KEY  = 8'hA5;
  localparam logic [7:0] PULSE_LEN = 8'(RST_PULSE_LEN);

  // Errors and mask are held 16 bits wide so both byte lanes always exist.
  // Error bits at or above ERR_WIDTH are never set, so they read back 0.
  logic [15:0]           sticky_q;
  logic [15:0]           mask_q;
  logic [DEBUG_BITS-1:0] debug_q;
  logic [7:0]            scratch_q;
  logic [7:0]            evcnt_q;
  logic [7:0]            srst_cnt_q;
  logic                  irq_q;

  logic        fetch_vld;
  logic        load_vld;
  logic [15:0] err16;
  logic [15:0] clr16;
  logic        new_err;
  logic [7:0]  debug8;

  // A fetch in the same cycle as a load wins; the load is dropped.
  assign fetch_vld = i_cs & i_fetch_cmd;
  assign load_vld  = i_cs & i_load_cmd & ~i_fetch_cmd;

  always_comb begin
    err16                  = '0;
    err16[ERR_WIDTH-1:0]   = i_error_list;
    debug8                 = '0;
    debug8[DEBUG_BITS-1:0] = debug_q;
    clr16                  = '0;
    if (load_vld && i_ioc == A_ERR_LO) clr16[7:0]  = i_data_in;
    if (load_vld && i_ioc == A_ERR_HI) clr16[15:8] = i_data_in;
  end

  // A bit that is becoming newly set counts as one event, however many
  // bits rise together.
  assign new_err = |(err16 & ~sticky_q);

  // Sticky errors: setting a bit wins over a simultaneous W1C of that bit.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      sticky_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      sticky_q <= (sticky_q & ~clr16) | err16;
      irq_q    <= |(sticky_q & mask_q);
    end
  end

  // Saturating event counter. A clear that coincides with an event
  // leaves the count at 1.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      evcnt_q <= '0;
    end else if (load_vld && i_ioc == A_EVCNT) begin
      evcnt_q <= new_err ? 8'd1 : 8'd0;
    end else if (new_err && evcnt_q != 8'hFF) begin
      evcnt_q <= evcnt_q + 8'd1;
    end
  end

  // Soft-reset pulse. The pulse is high while the counter is nonzero.
  // Writes during a pulse are ignored, so a pulse cannot be extended.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      srst_cnt_q <= '0;
    end else if (srst_cnt_q != 8'd0) begin
      srst_cnt_q <= srst_cnt_q - 8'd1;
    end else if (load_vld && i_ioc == A_SRST && i_data_in == SRST_KEY) begin
      srst_cnt_q <= PULSE_LEN;
    end
  end

  // Plain writable registers.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      debug_q   <= '0;
      scratch_q <= '0;
      mask_q    <= '0;
    end else if (load_vld) begin
      case (i_ioc)
        A_DEBUG:   debug_q      <= i_data_in[DEBUG_BITS-1:0];
        A_SCRATCH: scratch_q    <= i_data_in;
        A_MASK_LO: mask_q[7:0]  <= i_data_in;
        A_MASK_HI: mask_q[15:8] <= i_data_in;
        default:   ;
      endcase
    end
  end

  // Read data is registered and holds its value until the next fetch.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data_out <= '0;
    end else if (fetch_vld) begin
      case (i_ioc)
        A_MOD_VER: o_data_out <= MODULE_VERSION;
        A_SYS_VER: o_data_out <= SYSTEM_VERSION;
        A_MANU:    o_data_out <= MANU_ID;
        A_ERR_LO:  o_data_out <= sticky_q[7:0];
        A_ERR_HI:  o_data_out <= sticky_q[15:8];
        A_DEBUG:   o_data_out <= debug8;
        A_SCRATCH: o_data_out <= scratch_q;
        A_SRST:    o_data_out <= srst_cnt_q;
        A_MASK_LO: o_data_out <= mask_q[7:0];
        A_MASK_HI: o_data_out <= mask_q[15:8];
        A_EVCNT:   o_data_out <= evcnt_q;
        default:   o_data_out <= 8'h00;
      endcase
    end
  end

  assign o_debug_modes = debug_q;
  assign o_error_any   = |sticky_q;
  assign o_irq         = irq_q;
  assign o_soft_rst    = (srst_cnt_q != 8'd0);

endmodule

// File: tb/tb_sys_ctrl_regs.sv
// tb_sys_ctrl_regs: directed self-checking bench for sys_ctrl_regs.
//   Default parameters: ERR_WIDTH=8, DEBUG_BITS=3, RST_PULSE_LEN=16.
//   Inputs change 1 ns after a rising edge. Outputs are sampled at that point.
module tb_sys_ctrl_regs;

  logic       i_sys_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [4:0] i_ioc = '0;
  logic [7:0] i_data_in = '0;
  logic [7:0] o_data_out;
  logic       i_cs = 1'b0;
  logic       i_fetch_cmd = 1'b0;
  logic       i_load_cmd = 1'b0;
  logic [7:0] i_error_list = '0;
  logic [2:0] o_debug_modes;
  logic       o_error_any;
  logic       o_irq;
  logic       o_soft_rst;

  int total = 0;
  int bad = 0;

  sys_ctrl_regs dut (
    .i_sys_clk    (i_sys_clk),
    .i_rst        (i_rst),
    .i_ioc        (i_ioc),
    .i_data_in    (i_data_in),
    .o_data_out   (o_data_out),
    .i_cs         (i_cs),
    .i_fetch_cmd  (i_fetch_cmd),
    .i_load_cmd   (i_load_cmd),
    .i_error_list (i_error_list),
    .o_debug_modes(o_debug_modes),
    .o_error_any  (o_error_any),
    .o_irq        (o_irq),
    .o_soft_rst   (o_soft_rst)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  task automatic tick();
    @(posedge i_sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    i_cs = 1'b1; i_load_cmd = 1'b1; i_ioc = a; i_data_in = d;
    tick();
    i_cs = 1'b0; i_load_cmd = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] v);
    i_cs = 1'b1; i_fetch_cmd = 1'b1; i_ioc = a;
    tick();
    i_cs = 1'b0; i_fetch_cmd = 1'b0;
    v = o_data_out;
  endtask

  initial begin
    logic [7:0] v;
    int high;

    // Reset state
    #2;
    chk("rst_data_out", 16'(o_data_out), 16'h00);
    chk("rst_debug", 16'(o_debug_modes), 16'h0);
    chk("rst_err_any", 16'(o_error_any), 16'h0);
    chk("rst_irq", 16'(o_irq), 16'h0);
    chk("rst_soft_rst", 16'(o_soft_rst), 16'h0);
    tick(); tick();
    i_rst = 1'b0;
    tick();

    // Constant registers and an unmapped address
    rd(5'h00, v); chk("rd_mod_ver", 16'(v), 16'h02);
    rd(5'h01, v); chk("rd_sys_ver", 16'(v), 16'h01);
    rd(5'h02, v); chk("rd_manu", 16'(v), 16'h01);
    rd(5'h0F, v); chk("rd_unmapped", 16'(v), 16'h00);

    // A load without chip select is ignored
    i_load_cmd = 1'b1; i_ioc = 5'h06; i_data_in = 8'h77;
    tick();
    i_load_cmd = 1'b0;
    rd(5'h06, v); chk("no_cs_write", 16'(v), 16'h00);

    // Debug modes and scratch
    wr(5'h05, 8'hFF);
    chk("debug_out", 16'(o_debug_modes), 16'h7);
    rd(5'h05, v); chk("rd_debug", 16'(v), 16'h07);
    wr(5'h06, 8'h5A);
    rd(5'h06, v); chk("rd_scratch", 16'(v), 16'h5A);

    // A fetch and a load in the same cycle: the read wins, the write is dropped
    i_cs = 1'b1; i_fetch_cmd = 1'b1; i_load_cmd = 1'b1; i_ioc = 5'h06; i_data_in = 8'h33;
    tick();
    i_cs = 1'b0; i_fetch_cmd = 1'b0; i_load_cmd = 1'b0;
    chk("fetch_load_rd", 16'(o_data_out), 16'h5A);
    rd(5'h06, v); chk("fetch_load_drop", 16'(v), 16'h5A);

    // One-clock error pulse
    i_error_list = 8'h12;
    tick();
    i_error_list = 8'h00;
    chk("err_any_same", 16'(o_error_any), 16'h1);
    rd(5'h03, v); chk("rd_sticky", 16'(v), 16'h12);
    rd(5'h04, v); chk("rd_sticky_hi", 16'(v), 16'h00);
    rd(5'h0A, v); chk("evcnt_1", 16'(v), 16'h01);
    chk("irq_unmasked", 16'(o_irq), 16'h0);
    wr(5'h03, 8'h02);
    rd(5'h03, v); chk("w1c_partial", 16'(v), 16'h10);

    // Set wins over a simultaneous clear; the IRQ lags by one clock
    wr(5'h03, 8'h10);
    rd(5'h03, v); chk("w1c_all", 16'(v), 16'h00);
    chk("err_any_clr", 16'(o_error_any), 16'h0);
    wr(5'h08, 8'h10);
    rd(5'h08, v); chk("rd_mask", 16'(v), 16'h10);
    chk("irq_idle", 16'(o_irq), 16'h0);
    i_cs = 1'b1; i_load_cmd = 1'b1; i_ioc = 5'h03; i_data_in = 8'h10; i_error_list = 8'h10;
    tick();
    i_cs = 1'b0; i_load_cmd = 1'b0; i_error_list = 8'h00;
    chk("set_wins_any", 16'(o_error_any), 16'h1);
    chk("irq_not_yet", 16'(o_irq), 16'h0);
    tick();
    chk("irq_set", 16'(o_irq), 16'h1);
    rd(5'h03, v); chk("set_wins", 16'(v), 16'h10);
    wr(5'h08, 8'h00);
    chk("irq_mask_lag", 16'(o_irq), 16'h1);
    tick();
    chk("irq_masked", 16'(o_irq), 16'h0);
    tick();
    chk("irq_stays_0", 16'(o_irq), 16'h0);
    rd(5'h0A, v); chk("evcnt_2", 16'(v), 16'h02);

    // Counter saturation
    wr(5'h03, 8'hFF);
    for (int i = 0; i < 300; i++) begin
      i_error_list = 8'h01;
      tick();
      i_error_list = 8'h00;
      wr(5'h03, 8'h01);
    end
    rd(5'h0A, v); chk("evcnt_sat", 16'(v), 16'hFF);

    // A clear write that coincides with a new event leaves the count at 1
    i_cs = 1'b1; i_load_cmd = 1'b1; i_ioc = 5'h0A; i_data_in = 8'h00; i_error_list = 8'h01;
    tick();
    i_cs = 1'b0; i_load_cmd = 1'b0; i_error_list = 8'h00;
    rd(5'h0A, v); chk("evcnt_clr_inc", 16'(v), 16'h01);
    wr(5'h0A, 8'h5C);
    rd(5'h0A, v); chk("evcnt_clr", 16'(v), 16'h00);

    // Soft-reset pulse and the remaining-count readback
    wr(5'h07, 8'hA5);
    chk("srst_start", 16'(o_soft_rst), 16'h1);
    rd(5'h07, v); chk("srst_remaining", 16'(v), 16'h10);
    repeat (20) tick();
    chk("srst_end", 16'(o_soft_rst), 16'h0);

    // Pulse width, with a repeat write during pulse cycle 5
    wr(5'h07, 8'hA5);
    high = 0;
    for (int i = 1; i <= 24; i++) begin
      if (o_soft_rst) high++;
      if (i == 5) begin
        wr(5'h07, 8'hA5);
      end else begin
        tick();
      end
    end
    chk("srst_width", 16'(high), 16'd16);

    // A non-key value produces no pulse
    wr(5'h07, 8'h11);
    high = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_soft_rst) high++;
      tick();
    end
    chk("srst_bad_key", 16'(high), 16'd0);

    // Reset during a pulse clears everything immediately
    i_error_list = 8'h04;
    tick();
    i_error_list = 8'h00;
    wr(5'h08, 8'h04);
    wr(5'h07, 8'hA5);
    tick(); tick();
    chk("srst_mid", 16'(o_soft_rst), 16'h1);
    chk("irq_before_rst", 16'(o_irq), 16'h1);
    i_rst = 1'b1;
    #1;
    chk("rst_mid_srst", 16'(o_soft_rst), 16'h0);
    chk("rst_mid_irq", 16'(o_irq), 16'h0);
    chk("rst_mid_any", 16'(o_error_any), 16'h0);
    chk("rst_mid_debug", 16'(o_debug_modes), 16'h0);
    chk("rst_mid_data", 16'(o_data_out), 16'h00);
    tick();
    i_rst = 1'b0;
    tick();
    rd(5'h06, v); chk("rst_scratch", 16'(v), 16'h00);
    rd(5'h08, v); chk("rst_mask", 16'(v), 16'h00);
    rd(5'h07, v); chk("rst_srst_cnt", 16'(v), 16'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_regs.md
# sys_ctrl_regs

Parametrised system-control register block on the SMI/IOC register bus. It replaces the fixed 8-bit control block with:
- configurable error-vector and debug-mode widths;
- sticky, maskable error capture with interrupt output and a saturating error-event counter;
- read-back of every writable register;
- a timed soft-reset pulse generator.

It sits beside the other IOC-addressed modules and is selected by `i_cs`.

## Interface
- `ERR_WIDTH`, 8: width of `i_error_list`, legal 1..16.
- `DEBUG_BITS`, 3: number of debug-mode control bits, legal 1..8.
- `RST_PULSE_LEN`, 16: soft-reset pulse length in clocks, legal 1..255.
- `MODULE_VERSION`, 8'h02 / `SYSTEM_VERSION`, 8'h01 / `MANU_ID`, 8'h01: read-only constants.
- `i_sys_clk`  in  1  FPGA system clock; single clock domain.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_ioc`  in  5  register address.
- `i_data_in`  in  8  write data.
- `o_data_out`  out  8  registered read data.
- `i_cs`  in  1  module select; fetch/load are ignored when low.
- `i_fetch_cmd`  in  1  read strobe, one clock.
- `i_load_cmd`  in  1  write strobe, one clock.
- `i_error_list`  in  ERR_WIDTH  synchronous error flags, level or pulse.
- `o_debug_modes`  out  DEBUG_BITS  debug control bits (bit0 fifo_push, bit1 fifo_pull, bit2 smi_test).
- `o_error_any`  out  1  OR of the sticky error register.
- `o_irq`  out  1  OR of (sticky & mask), registered.
- `o_soft_rst`  out  1  soft-reset pulse, active-high.

## Operation
Register map (R = read, W = write):
- 0x00 R MODULE_VERSION.
- 0x01 R SYSTEM_VERSION.
- 0x02 R MANU_ID.
- 0x03 R/W1C sticky errors [7:0].
- 0x04 R/W1C sticky errors [15:8]; bits at or above ERR_WIDTH read 0.
- 0x05 R/W debug modes; upper unused bits read 0.
- 0x06 R/W scratch, 8 bits.
- 0x07 W soft-reset command; reads return the remaining pulse count.
- 0x08 R/W IRQ mask [7:0].
- 0x09 R/W IRQ mask [15:8].
- 0x0A R error-event counter; any write clears it.

Access rules:
- Unmapped addresses: reads return 8'h00; writes are ignored.
- Fetch and load in the same cycle: the fetch is performed and the load is dropped.
- Sticky errors: every clock, `sticky <= (sticky & ~clr) | i_error_list`. Set wins over a simultaneous W1C clear of the same bit.
- Event counter: increments by 1 in any cycle where `(i_error_list & ~sticky) != 0`, i.e. a new bit is becoming set. It saturates at 8'hFF. A clear-write in the same cycle as an increment leaves the counter at 1.
- Soft reset: a write of 8'hA5 to 0x07 loads the counter with RST_PULSE_LEN and asserts `o_soft_rst`. The counter decrements each clock and `o_soft_rst` deasserts when it reaches 0.
  - Writes to 0x07 while the pulse is active are ignored; the pulse is not extended.
  - Any value other than 8'hA5 is ignored.
- `o_soft_rst` does not reset this block.
- `i_rst` asynchronously clears every register and output:
  - `o_data_out`, sticky, mask, scratch, debug and counter all go to 0;
  - `o_soft_rst`, `o_irq` and `o_error_any` go to 0.
- Reset asserted mid-pulse terminates the pulse immediately.

## Timing
- Read latency: `o_data_out` updates on the clock edge that samples the fetch and holds its value until the next fetch.
- Write latency: the register and `o_debug_modes` update on the edge that samples the load.
- Error capture: sticky is set on the edge that samples `i_error_list`. `o_error_any` is combinational from sticky, so it is high in the same cycle sticky is set.
- `o_irq` is registered, asserting 1 clock after sticky & mask becomes nonzero. It also follows a mask write with 1 clock of latency.
- `o_soft_rst` is high for exactly RST_PULSE_LEN clocks, starting the cycle after the 0xA5 write edge.
- No back-pressure: one access per clock is allowed, and back-to-back strobes are legal.

## Test plan
- Reset, then fetch 0x00 / 0x01 / 0x02 / 0x0F -> `o_data_out` = 8'h02 / 8'h01 / 8'h01 / 8'h00, each one clock after its fetch.
- Write 0x05 = 8'hFF with DEBUG_BITS=3 -> `o_debug_modes` = 3'b111, and fetch 0x05 returns 8'h07. Then write 0x06 = 8'h5A and fetch it -> 8'h5A.
- Pulse `i_error_list` = 8'h12 for one clock -> 0x03 reads 8'h12, `o_error_any` = 1, counter = 1. Write 0x03 = 8'h02 -> 0x03 reads 8'h10.
- With mask 0x08 = 8'h10, assert error bit 4 while writing W1C 0x10 in the same cycle -> sticky bit 4 remains set and `o_irq` = 1 one clock later. With mask 0, `o_irq` stays 0.
- Toggle a new error bit 300 times, clearing it between toggles -> counter reads 8'hFF. Write 0x0A -> counter reads 8'h00.
- Write 0x07 = 8'hA5 with RST_PULSE_LEN=16 -> `o_soft_rst` is high for 16 clocks.
  - A repeat 0xA5 write at pulse cycle 5 does not extend the pulse.
  - A write of 8'h11 produces no pulse.
  - Asserting `i_rst` mid-pulse drops `o_soft_rst` immediately.
